multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Finite-state control unit that sequences the ARM-subset datapath one instruction at a time. It decodes the fetched word, evaluates the condition field against an internal NZCV flags register, and drives every datapath control input. It stalls on a variable-latency data memory through a ready handshake and gates PC advance with an explicit PCWrite strobe. It sits between instruction memory, data memory and the datapath.

## Interface
- MEM_TIMEOUT, default 16: maximum cycles spent in S_MEM waiting for mem_ready. Legal range 1..255.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  32  instruction word at the current PC. Sampled only in S_FETCH.
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- mem_ready  in  1  data memory has completed the current read or write.
- PCWrite  out  1  PC register load enable.
- PCSrc  out  1  1 selects Result as the next PC.
- RegSrc  out  2  [0]=1 reads R15 as A; [1]=1 reads Rd as B.
- RegWrite  out  1  register file write enable.
- ALUSrc  out  1  1 selects the extended immediate as B.
- ALUControl  out  4  ALU operation code, encodings listed under Operation.
- MemtoReg  out  1  1 selects ReadData as Result.
- MemWrite  out  1  data memory write request.
- MemRead  out  1  data memory read request.
- inm  out  24  IR[23:0], forwarded to the extender.
- Flags  out  4  architectural NZCV register.
- instr_done  out  1  one-cycle pulse when an instruction retires (equals PCWrite).
- mem_err  out  1  sticky. Set on memory timeout, cleared only by reset.

## Operation
- The instruction register IR is loaded from Instr in S_FETCH. IR fields:
  - cond = IR[31:28]
  - op = IR[27:26]
  - I = IR[25]
  - cmd = IR[24:21]
  - S = IR[20]
  - L = IR[20]
  - U = IR[23]
  - Rd = IR[15:12]
- ALU encodings:
  - ADD 0000, SUB 0001, AND 0010, ORR 0011, EOR 0100, MOV 0101.
  - Data-processing cmd mapping: 0100→ADD, 0010→SUB, 1010 (CMP)→SUB, 0000→AND, 1100→ORR, 0001→EOR, 1101→MOV.
  - Any other cmd executes as ADD with RegWrite=0.
- Conditions: standard ARM EQ..LE evaluated on Flags. 1110 (AL) and 1111 always pass.
- States:
  - S_FETCH: load IR. Go to S_DECODE.
  - S_DECODE: all outputs 0.
    - Condition fails → S_RETIRE.
    - op=00 → S_EXEC.
    - op=01 → S_MEM.
    - op=10 → S_BRANCH.
    - op=11 → S_RETIRE (executes as NOP).
  - S_EXEC:
    - ALUSrc=I; ALUControl from cmd.
    - RegWrite=1 except for CMP.
    - Flags←ALUFlags when S=1 or CMP.
    - If Rd=15 and RegWrite: PCSrc=1.
    - PCWrite=1. Go to S_FETCH.
  - S_MEM:
    - ALUSrc=1; ALUControl=ADD if U else SUB.
    - Store (L=0): MemWrite=1, RegSrc[1]=1.
    - Load (L=1): MemRead=1.
    - Outputs are held stable while waiting.
    - mem_ready=1 on a store → PCWrite=1, go to S_FETCH.
    - mem_ready=1 on a load → S_WB.
    - Wait counter reaches MEM_TIMEOUT without mem_ready → set mem_err, drop requests, go to S_RETIRE.
  - S_WB: keeps the S_MEM ALU settings; MemtoReg=1, RegWrite=1, PCWrite=1. Go to S_FETCH.
  - S_BRANCH: RegSrc[0]=1, ALUSrc=1, ALUControl=ADD, PCSrc=1, PCWrite=1. Go to S_FETCH.
  - S_RETIRE: PCWrite=1, PCSrc=0. Go to S_FETCH.
- All outputs are Moore-style, decoded from state and IR. The exception is the S_MEM exit, which depends on mem_ready.

## Timing
- Reset: while reset is high and on the following edge, the FSM goes to S_FETCH and IR, Flags and the wait counter clear to 0.
  - mem_err clears to 0.
  - All control outputs read 0 during reset, so no register, memory or PC write occurs.
- Reset asserted mid-instruction aborts that instruction without side effects in the reset cycle.
- Cycle counts per instruction:
  - Data-processing: 3.
  - Branch: 3.
  - Condition-failed or NOP: 3.
  - Store: 3+w, where w = cycles before mem_ready.
  - Load: 4+w.
  - Timeout: 3+MEM_TIMEOUT+1.
- mem_ready outside S_MEM is ignored.
- mem_ready asserted in the first S_MEM cycle gives w=0.
- The Flags update takes effect on the S_EXEC edge, so the next instruction's S_DECODE sees the new flags.
- The wait counter width is 8 bits. It clears on entry to S_MEM and saturates; it does not wrap.

## Structure
- Package ctrl_pkg holds:
  - The state enum.
  - The ALU code and cmd constants.
  - The op and cond constants.
  - The flag bit indices.
- Sub-module cond_check: combinational, inputs cond[3:0] and flags[3:0], output pass.

## Test plan
- ADD R1,R2,#5 (0xE2821005) with ALUFlags=0000 → cycle 3: ALUSrc=1, ALUControl=0000, RegWrite=1, PCWrite=1; Flags unchanged.
- CMP (0xE1510002) with ALUFlags=0100, then BEQ (0x0A000002) → Flags=0100; the branch asserts PCSrc=1 and RegSrc=01. Repeat with ALUFlags=0000 → the branch retires with PCSrc=0.
- LDR (0xE5912004) with mem_ready asserted after 2 cycles → MemRead high for 3 cycles, then S_WB with MemtoReg=1, RegWrite=1. Total 6 cycles.
- STR with mem_ready never asserted, MEM_TIMEOUT=4 → MemWrite high 4 cycles, mem_err=1, RegWrite never asserted, PCWrite pulses once.
- Reset asserted in S_MEM during a store → MemWrite=0 in the reset cycle; FSM in S_FETCH and Flags=0000 afterwards.
- op=11 word and cond=1111 word → the first retires as NOP in 3 cycles with no writes; the second executes unconditionally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_RETIRE
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Returns {known, alu_code}; unknown commands fall back to ADD with no write.
  function automatic logic [4:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: return {1'b1, ALU_ADD};
      CMD_SUB: return {1'b1, ALU_SUB};
      CMD_CMP: return {1'b1, ALU_SUB};
      CMD_AND: return {1'b1, ALU_AND};
      CMD_ORR: return {1'b1, ALU_ORR};
      CMD_EOR: return {1'b1, ALU_EOR};
      CMD_MOV: return {1'b1, ALU_MOV};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath/memory-facing signal bundle of the multicycle control unit.
interface multicycle_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite;
  logic        PCSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic        ALUSrc;
  logic [3:0]  ALUControl;
  logic        MemtoReg;
  logic        MemWrite;
  logic        MemRead;
  logic [23:0] inm;
  logic [3:0]  Flags;
  logic        instr_done;
  logic        mem_err;

  // Controller side
  modport master (
    input  Instr, ALUFlags, mem_ready,
    output PCWrite, PCSrc, RegSrc, RegWrite, ALUSrc, ALUControl,
           MemtoReg, MemWrite, MemRead, inm, Flags, instr_done, mem_err
  );

  // Datapath / memory side
  modport slave (
    output Instr, ALUFlags, mem_ready,
    input  PCWrite, PCSrc, RegSrc, RegWrite, ALUSrc, ALUControl,
           MemtoReg, MemWrite, MemRead, inm, Flags, instr_done, mem_err
  );
endinterface

// File: rtl/cond_check.sv
// ARM condition-field evaluation against the NZCV register.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Condition table lookup
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control unit: fetch/decode/execute sequencing, NZCV register,
// data-memory ready handshake with timeout.
//
// state    | meaning
// S_FETCH  | latch instruction word into IR
// S_DECODE | evaluate condition, dispatch on op
// S_EXEC   | data-processing, optional flag update, retire
// S_MEM    | address calc + memory request, wait for mem_ready
// S_WB     | load write-back, retire
// S_BRANCH | PC <- PC-relative target, retire
// S_RETIRE | advance PC only (cond fail, NOP, memory timeout)
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t      state;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic [7:0]  wait_cnt;
  logic        mem_err_q;

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic       i_bit, s_bit, u_bit;
  assign cond  = ir[31:28];
  assign op    = ir[27:26];
  assign i_bit = ir[25];
  assign cmd   = ir[24:21];
  assign u_bit = ir[23];
  assign s_bit = ir[20];   // also L for memory ops
  assign rd    = ir[15:12];

  logic cond_pass;
  cond_check u_cond (.cond(cond), .flags(flags), .pass(cond_pass));

  logic       dp_known, dp_write, timeout;
  logic [3:0] dp_alu, mem_alu;
  assign {dp_known, dp_alu} = alu_decode(cmd);
  assign dp_write = dp_known && (cmd != CMD_CMP);
  assign mem_alu  = u_bit ? ALU_ADD : ALU_SUB;
  // Timeout wins over a late mem_ready so the request drop is clean.
  assign timeout  = (wait_cnt == TIMEOUT_CNT);

  // State, IR, flags, wait counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      flags     <= '0;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= bus.Instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (!cond_pass) state <= S_RETIRE;
          else begin
            case (op)
              OP_DP:  state <= S_EXEC;
              OP_MEM: begin
                wait_cnt <= '0;
                state    <= S_MEM;
              end
              OP_BR:  state <= S_BRANCH;
              OP_NOP: state <= S_RETIRE;
            endcase
          end
        end
        S_EXEC: begin
          if (s_bit || cmd == CMD_CMP) flags <= bus.ALUFlags;
          state <= S_FETCH;
        end
        S_MEM: begin
          if (timeout) begin
            mem_err_q <= 1'b1;
            state     <= S_RETIRE;
          end else if (bus.mem_ready) begin
            state <= s_bit ? S_WB : S_FETCH;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  logic       pc_write, pc_src, reg_write, alu_src, mem_to_reg, mem_write, mem_read;
  logic [1:0] reg_src;
  logic [3:0] alu_ctl;

  // Moore decode from state/IR; reset forces every control low at once
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_src    = 2'b00;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_ctl    = ALU_ADD;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    if (!reset) begin
      case (state)
        S_EXEC: begin
          alu_src   = i_bit;
          alu_ctl   = dp_alu;
          reg_write = dp_write;
          pc_src    = dp_write && (rd == 4'hF);
          pc_write  = 1'b1;
        end
        S_MEM: begin
          alu_src = 1'b1;
          alu_ctl = mem_alu;
          if (!s_bit) begin
            reg_src[1] = 1'b1;
            mem_write  = !timeout;
            pc_write   = !timeout && bus.mem_ready;
          end else begin
            mem_read = !timeout;
          end
        end
        S_WB: begin
          alu_src    = 1'b1;
          alu_ctl    = mem_alu;
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          pc_write   = 1'b1;
        end
        S_BRANCH: begin
          reg_src[0] = 1'b1;
          alu_src    = 1'b1;
          alu_ctl    = ALU_ADD;
          pc_src     = 1'b1;
          pc_write   = 1'b1;
        end
        S_RETIRE: pc_write = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.PCSrc      = pc_src;
  assign bus.RegSrc     = reg_src;
  assign bus.RegWrite   = reg_write;
  assign bus.ALUSrc     = alu_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.MemWrite   = mem_write;
  assign bus.MemRead    = mem_read;
  assign bus.inm        = ir[23:0];
  assign bus.Flags      = flags;
  assign bus.instr_done = pc_write;
  assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed vector table, reset corner
// cases, and random instructions against a trace-level reference model.
module tb_multicycle_controller;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller #(.MEM_TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [13:0] ctrl;
    logic [3:0]  flags;
    logic        err;
    logic [23:0] inm;
  } rec_t;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  af;
    int          w;
    int          cycles;
    logic        pcs;
    logic [1:0]  rs;
    logic        rw;
    logic        mtr;
    int          mw;
    int          mr;
    int          pcw;
    logic [3:0]  flags;
    logic        err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  rec_t obs_q[$];
  rec_t exp_q[$];
  logic [3:0]  post_flags;
  logic        post_err;
  logic [3:0]  m_flags;
  logic        m_err;
  logic [31:0] m_ir;
  logic [4:0]  dp_tbl[16];
  vec_t        tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {PCWrite, PCSrc, RegSrc, RegWrite, ALUSrc, ALUControl, MemtoReg, MemWrite, MemRead, instr_done}
  function automatic logic [13:0] ctl(input logic pcw, input logic pcs, input logic [1:0] rs,
                                      input logic rw, input logic as, input logic [3:0] ac,
                                      input logic mtr, input logic mw, input logic mr);
    return {pcw, pcs, rs, rw, as, ac, mtr, mw, mr, pcw};
  endfunction

  function automatic rec_t observe();
    rec_t r;
    r.ctrl  = {bus.PCWrite, bus.PCSrc, bus.RegSrc, bus.RegWrite, bus.ALUSrc, bus.ALUControl,
               bus.MemtoReg, bus.MemWrite, bus.MemRead, bus.instr_done};
    r.flags = bus.Flags;
    r.err   = bus.mem_err;
    r.inm   = bus.inm;
    return r;
  endfunction

  // ARM rule: pairs of conditions share a base test, odd codes invert it.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, b;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  // Expected per-cycle output trace of one instruction; updates model state.
  function automatic void model_instr(input logic [31:0] ins, input logic [3:0] af, input int w);
    rec_t r;
    logic [3:0] cmd = ins[24:21];
    logic [3:0] mem_alu = ins[23] ? 4'b0000 : 4'b0001;
    logic       store = !ins[20];
    logic [1:0] mem_rs = store ? 2'b10 : 2'b00;
    logic       dp_rw;
    exp_q.delete();
    r.ctrl = '0; r.flags = m_flags; r.err = m_err; r.inm = m_ir[23:0];
    exp_q.push_back(r);
    m_ir = ins;
    r.inm = ins[23:0];
    exp_q.push_back(r);
    if (!cond_ok(ins[31:28], m_flags) || ins[27:26] == 2'b11) begin
      r.ctrl = ctl(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(r);
    end else if (ins[27:26] == 2'b00) begin
      dp_rw = dp_tbl[cmd][4] && (cmd != 4'b1010);
      r.ctrl = ctl(1'b1, dp_rw && (ins[15:12] == 4'hF), 2'b00, dp_rw, ins[25], dp_tbl[cmd][3:0],
                   1'b0, 1'b0, 1'b0);
      exp_q.push_back(r);
      if (ins[20] || cmd == 4'b1010) m_flags = af;
    end else if (ins[27:26] == 2'b10) begin
      r.ctrl = ctl(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(r);
    end else if (w < T) begin
      r.ctrl = ctl(1'b0, 1'b0, mem_rs, 1'b0, 1'b1, mem_alu, 1'b0, store, !store);
      for (int k = 0; k < w; k++) exp_q.push_back(r);
      r.ctrl = ctl(store, 1'b0, mem_rs, 1'b0, 1'b1, mem_alu, 1'b0, store, !store);
      exp_q.push_back(r);
      if (!store) begin
        r.ctrl = ctl(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, mem_alu, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(r);
      end
    end else begin
      r.ctrl = ctl(1'b0, 1'b0, mem_rs, 1'b0, 1'b1, mem_alu, 1'b0, store, !store);
      for (int k = 0; k < T; k++) exp_q.push_back(r);
      r.ctrl = ctl(1'b0, 1'b0, mem_rs, 1'b0, 1'b1, mem_alu, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(r);
      m_err = 1'b1;
      r.err = 1'b1;
      r.ctrl = ctl(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(r);
    end
  endfunction

  // Called just after a rising edge with the DUT in fetch. Noise on Instr and
  // on mem_ready outside the memory window must be ignored.
  task automatic exec_instr(input logic [31:0] ins, input logic [3:0] af, input int w);
    bit done = 1'b0;
    obs_q.delete();
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      bus.Instr     = (cyc == 0) ? ins : $urandom();
      bus.ALUFlags  = af;
      bus.mem_ready = (cyc < 2) ? 1'($urandom_range(0, 1)) : (cyc == 2 + w);
      @(negedge clk);
      obs_q.push_back(observe());
      done = bus.instr_done;
    end
    if (!done) check("instr_done_bound", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    post_flags = bus.Flags;
    post_err   = bus.mem_err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, mw, mr, pcw;
    logic pcs, rw, mtr;
    logic [1:0] rs;
    logic [31:0] ins;
    logic [3:0] af;
    int w;

    for (int k = 0; k < 16; k++) dp_tbl[k] = 5'b0_0000;
    dp_tbl[4'b0100] = 5'b1_0000;
    dp_tbl[4'b0010] = 5'b1_0001;
    dp_tbl[4'b1010] = 5'b1_0001;
    dp_tbl[4'b0000] = 5'b1_0010;
    dp_tbl[4'b1100] = 5'b1_0011;
    dp_tbl[4'b0001] = 5'b1_0100;
    dp_tbl[4'b1101] = 5'b1_0101;

    //          ins           af     w  cyc pcs rs     rw mtr mw mr pcw flags  err
    tbl[0]  = '{32'hE2821005, 4'h0, 0, 3, 0, 2'b00, 1, 0, 0, 0, 1, 4'h0, 0};
    tbl[1]  = '{32'hE1510002, 4'h4, 0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 4'h4, 0};
    tbl[2]  = '{32'h0A000002, 4'h0, 0, 3, 1, 2'b01, 0, 0, 0, 0, 1, 4'h4, 0};
    tbl[3]  = '{32'hE1510002, 4'h0, 0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 4'h0, 0};
    tbl[4]  = '{32'h0A000002, 4'h0, 0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 4'h0, 0};
    tbl[5]  = '{32'hE5912004, 4'h0, 2, 6, 0, 2'b00, 1, 1, 0, 3, 1, 4'h0, 0};
    tbl[6]  = '{32'hE5812004, 4'h0, 1, 4, 0, 2'b10, 0, 0, 2, 0, 1, 4'h0, 0};
    tbl[7]  = '{32'hEC000000, 4'h0, 0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 4'h0, 0};
    tbl[8]  = '{32'hF2821005, 4'h0, 0, 3, 0, 2'b00, 1, 0, 0, 0, 1, 4'h0, 0};
    tbl[9]  = '{32'h02821005, 4'h0, 0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 4'h0, 0};
    tbl[10] = '{32'hE29FF004, 4'h9, 0, 3, 1, 2'b00, 1, 0, 0, 0, 1, 4'h9, 0};
    tbl[11] = '{32'hE2CFF000, 4'h6, 0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 4'h9, 0};
    tbl[12] = '{32'hA2821005, 4'h0, 0, 3, 0, 2'b00, 1, 0, 0, 0, 1, 4'h9, 0};
    tbl[13] = '{32'hB2821005, 4'h0, 0, 3, 0, 2'b00, 0, 0, 0, 0, 1, 4'h9, 0};
    tbl[14] = '{32'hE5812004, 4'h0, 9, 8, 0, 2'b10, 0, 0, 4, 0, 1, 4'h9, 1};

    // Reset state
    bus.Instr = 32'hE5812004; bus.ALUFlags = 4'hF; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 64'(observe().ctrl), 64'(0));
    check("reset_flags", 64'(bus.Flags), 64'(0));
    check("reset_err", 64'(bus.mem_err), 64'(0));
    check("reset_inm", 64'(bus.inm), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    check("fetch_ctrl", 64'(observe().ctrl), 64'(0));

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      exec_instr(tbl[i].ins, tbl[i].af, tbl[i].w);
      cycles = obs_q.size();
      pcs = 0; rs = 0; rw = 0; mtr = 0; mw = 0; mr = 0; pcw = 0;
      foreach (obs_q[k]) begin
        pcs = pcs | obs_q[k].ctrl[12];
        rs  = rs  | obs_q[k].ctrl[11:10];
        rw  = rw  | obs_q[k].ctrl[9];
        mtr = mtr | obs_q[k].ctrl[3];
        mw  = mw  + int'(obs_q[k].ctrl[2]);
        mr  = mr  + int'(obs_q[k].ctrl[1]);
        pcw = pcw + int'(obs_q[k].ctrl[13]);
      end
      check($sformatf("v%0d cycles", i), 64'(cycles), 64'(tbl[i].cycles));
      check($sformatf("v%0d PCSrc", i), 64'(pcs), 64'(tbl[i].pcs));
      check($sformatf("v%0d RegSrc", i), 64'(rs), 64'(tbl[i].rs));
      check($sformatf("v%0d RegWrite", i), 64'(rw), 64'(tbl[i].rw));
      check($sformatf("v%0d MemtoReg", i), 64'(mtr), 64'(tbl[i].mtr));
      check($sformatf("v%0d MemWrite_cycles", i), 64'(mw), 64'(tbl[i].mw));
      check($sformatf("v%0d MemRead_cycles", i), 64'(mr), 64'(tbl[i].mr));
      check($sformatf("v%0d PCWrite_pulses", i), 64'(pcw), 64'(tbl[i].pcw));
      check($sformatf("v%0d Flags", i), 64'(post_flags), 64'(tbl[i].flags));
      check($sformatf("v%0d mem_err", i), 64'(post_err), 64'(tbl[i].err));
    end

    // Reset while a store waits in memory
    bus.Instr = 32'hE5812004; bus.ALUFlags = 4'h0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset MemWrite_before", 64'(bus.MemWrite), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midreset MemWrite_in_reset", 64'(bus.MemWrite), 64'(0));
    check("midreset ctrl_in_reset", 64'(observe().ctrl), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("midreset ctrl_after", 64'(observe().ctrl), 64'(0));
    check("midreset Flags_after", 64'(bus.Flags), 64'(0));
    check("midreset err_after", 64'(bus.mem_err), 64'(0));
    exec_instr(32'hE2821005, 4'h0, 0);
    check("midreset next_cycles", 64'(obs_q.size()), 64'(3));
    check("midreset next_RegWrite", 64'(obs_q[obs_q.size()-1].ctrl[9]), 64'(1));

    // Random instructions against the reference model
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_flags = 4'h0; m_err = 1'b0; m_ir = 32'h0;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom();
      if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
      af = 4'($urandom());
      w  = int'($urandom_range(0, T + 1));
      model_instr(ins, af, w);
      exec_instr(ins, af, w);
      check($sformatf("rnd%0d trace_len %08h", n, ins), 64'(obs_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
        check($sformatf("rnd%0d cyc%0d %08h", n, k, ins), 64'(obs_q[k]), 64'(exp_q[k]));
      check($sformatf("rnd%0d post_flags", n), 64'(post_flags), 64'(m_flags));
      check($sformatf("rnd%0d post_err", n), 64'(post_err), 64'(m_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
